calc_entry_ctrl: RTL and testbench

Keypad entry sequencer for the two-operand decimal calculator. It takes the 12-key one-hot push-switch bus and debounces it. It then sequences operand A, operand B and a digit-serial BCD addition, and echoes accepted keys to the LCD character writer over a busy/write handshake. It sits between the push-switch inputs and the LCD/7-segment display logic, and is the only block that updates the operand and result registers.

---
 rtl/calc_entry_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_calc_entry_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_entry_ctrl.sv
// Keypad entry sequencer: debounces the one-hot key bus, builds two BCD operands and adds them.
// Define CALC_ECHO_EN to enable the one-entry LCD echo buffer and busy/write handshake.
module calc_entry_ctrl #(
    parameter int unsigned MAX_DIGITS   = 2,
    parameter int unsigned DEBOUNCE_CYC = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [11:0]               i_sw_push,
    input  logic                      i_lcd_busy,
    output logic                      o_lcd_wr,
    output logic [7:0]                o_lcd_data,
    output logic [4*MAX_DIGITS-1:0]   o_opnd_a,
    output logic [4*MAX_DIGITS-1:0]   o_opnd_b,
    output logic [4*MAX_DIGITS+3:0]   o_result,
    output logic                      o_result_vld,
    output logic [1:0]                o_state
);

    localparam int unsigned OPW  = 4 * MAX_DIGITS;
    localparam int unsigned RESW = OPW + 4;
    localparam int unsigned CNTW = $clog2(DEBOUNCE_CYC);
    localparam int unsigned NDW  = $clog2(MAX_DIGITS + 1);
    localparam int unsigned IDXW = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_ADD  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [11:0]       last_q;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              armed_q, armed_d;
    logic [OPW-1:0]    a_q, a_d, b_q, b_d;
    logic [RESW-1:0]   res_q, res_d;
    logic              vld_q, vld_d;
    logic [NDW-1:0]    nda_q, nda_d, ndb_q, ndb_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;

    logic              key_vld, key_evt, clr_evt;
    logic [3:0]        dig;
    logic              can_echo, echo_req;
    logic [7:0]        echo_ch;
    logic [3:0]        a_dig, b_dig;
    logic [4:0]        dsum;

    assign key_vld = (i_sw_push != '0) && ((i_sw_push & (i_sw_push - 12'd1)) == '0);

    // Count stays parked at DEBOUNCE_CYC-1 so a long hold fires exactly once while armed.
    always_comb begin
        cnt_d   = cnt_q;
        armed_d = armed_q;
        key_evt = 1'b0;
        if (!key_vld) begin
            cnt_d   = '0;
            armed_d = 1'b1;
        end else if (i_sw_push != last_q) begin
            cnt_d = CNTW'(1);
        end else if (cnt_q == CNTW'(DEBOUNCE_CYC - 1)) begin
            key_evt = armed_q;
            armed_d = 1'b0;
        end else begin
            cnt_d = cnt_q + CNTW'(1);
        end
    end

    always_comb begin
        dig = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (i_sw_push[11-i]) dig = 4'(i);
        end
    end

    assign clr_evt = key_evt && i_sw_push[0];

    assign a_dig = a_q[4*idx_q +: 4];
    assign b_dig = b_q[4*idx_q +: 4];
    assign dsum  = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0, carry_q};

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        vld_d    = vld_q;
        nda_d    = nda_q;
        ndb_d    = ndb_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        echo_req = 1'b0;
        echo_ch  = 8'h20;

        if (state_q == S_ADD) begin
            if (dsum > 5'd9) begin
                res_d[4*idx_q +: 4] = 4'(dsum - 5'd10);
                carry_d             = 1'b1;
            end else begin
                res_d[4*idx_q +: 4] = dsum[3:0];
                carry_d             = 1'b0;
            end
            if (idx_q == IDXW'(MAX_DIGITS - 1)) begin
                res_d[OPW +: 4] = {3'b0, carry_d};
                vld_d           = 1'b1;
                state_d         = S_DONE;
            end else begin
                idx_d = idx_q + IDXW'(1);
            end
        end

        if (key_evt) begin
            if (i_sw_push[0]) begin
                state_d = S_A;
                a_d     = '0;
                b_d     = '0;
                res_d   = '0;
                vld_d   = 1'b0;
                nda_d   = '0;
                ndb_d   = '0;
                idx_d   = '0;
                carry_d = 1'b0;
            end else if (i_sw_push[1]) begin
                if (state_q == S_A && can_echo) begin
                    state_d  = S_B;
                    echo_req = 1'b1;
                    echo_ch  = 8'h2B;
                end else if (state_q == S_B && can_echo) begin
                    state_d  = S_ADD;
                    res_d    = '0;
                    vld_d    = 1'b0;
                    idx_d    = '0;
                    carry_d  = 1'b0;
                    echo_req = 1'b1;
                    echo_ch  = 8'h3D;
                end
            end else begin
                if (state_q == S_A) begin
                    if (nda_q < NDW'(MAX_DIGITS) && can_echo) begin
                        a_d      = (a_q << 4) | OPW'(dig);
                        nda_d    = nda_q + NDW'(1);
                        echo_req = 1'b1;
                        echo_ch  = 8'h30 + {4'h0, dig};
                    end
                end else if (state_q == S_B) begin
                    if (ndb_q < NDW'(MAX_DIGITS) && can_echo) begin
                        b_d      = (b_q << 4) | OPW'(dig);
                        ndb_d    = ndb_q + NDW'(1);
                        echo_req = 1'b1;
                        echo_ch  = 8'h30 + {4'h0, dig};
                    end
                end else if (state_q == S_DONE && can_echo) begin
                    state_d  = S_A;
                    a_d      = OPW'(dig);
                    b_d      = '0;
                    res_d    = '0;
                    vld_d    = 1'b0;
                    nda_d    = NDW'(1);
                    ndb_d    = '0;
                    echo_req = 1'b1;
                    echo_ch  = 8'h30 + {4'h0, dig};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_A;
            last_q  <= '0;
            cnt_q   <= '0;
            armed_q <= 1'b1;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            vld_q   <= 1'b0;
            nda_q   <= '0;
            ndb_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= i_sw_push;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            vld_q   <= vld_d;
            nda_q   <= nda_d;
            ndb_q   <= ndb_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
        end
    end

`ifdef CALC_ECHO_EN
    logic       echo_full_q, echo_full_d;
    logic [7:0] echo_char_q, echo_char_d;
    logic [7:0] lcd_data_q, lcd_data_d;

    assign can_echo   = !echo_full_q;
    // Strobe is combinational on busy so it lands on the first idle cycle; rst/CLR squash it.
    assign o_lcd_wr   = echo_full_q && !i_lcd_busy && !clr_evt && !rst;
    assign o_lcd_data = o_lcd_wr ? echo_char_q : lcd_data_q;

    always_comb begin
        echo_full_d = echo_full_q;
        echo_char_d = echo_char_q;
        lcd_data_d  = lcd_data_q;
        if (o_lcd_wr) begin
            echo_full_d = 1'b0;
            lcd_data_d  = echo_char_q;
        end
        if (echo_req) begin
            echo_full_d = 1'b1;
            echo_char_d = echo_ch;
        end
        if (clr_evt) begin
            echo_full_d = 1'b0;
            echo_char_d = 8'h20;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            echo_full_q <= 1'b0;
            echo_char_q <= 8'h20;
            lcd_data_q  <= 8'h20;
        end else begin
            echo_full_q <= echo_full_d;
            echo_char_q <= echo_char_d;
            lcd_data_q  <= lcd_data_d;
        end
    end
`else
    logic unused_echo;

    assign can_echo    = 1'b1;
    assign o_lcd_wr    = 1'b0;
    assign o_lcd_data  = 8'h20;
    assign unused_echo = ^{echo_req, echo_ch, i_lcd_busy};
`endif

    assign o_opnd_a     = a_q;
    assign o_opnd_b     = b_q;
    assign o_result     = res_q;
    assign o_result_vld = vld_q;
    assign o_state      = state_q;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Scoreboard bench for calc_entry_ctrl: queued echo characters and sums, checked as the DUT emits them.
module tb_calc_entry_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [11:0] sw, sw2;
    logic        busy, busy2;

    logic        lcd_wr, lcd_wr2;
    logic [7:0]  lcd_data, lcd_data2;
    logic [7:0]  opnd_a, opnd_b;
    logic [11:0] result;
    logic        result_vld, result_vld2;
    logic [1:0]  state, state2;
    logic [15:0] opnd_a2, opnd_b2;
    logic [19:0] result2;

    calc_entry_ctrl #(.MAX_DIGITS(2), .DEBOUNCE_CYC(4)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .i_sw_push    (sw),
        .i_lcd_busy   (busy),
        .o_lcd_wr     (lcd_wr),
        .o_lcd_data   (lcd_data),
        .o_opnd_a     (opnd_a),
        .o_opnd_b     (opnd_b),
        .o_result     (result),
        .o_result_vld (result_vld),
        .o_state      (state)
    );

    // Longer add with short debounce so CLR can land mid-add.
    calc_entry_ctrl #(.MAX_DIGITS(4), .DEBOUNCE_CYC(2)) u_dut2 (
        .clk          (clk),
        .rst          (rst),
        .i_sw_push    (sw2),
        .i_lcd_busy   (busy2),
        .o_lcd_wr     (lcd_wr2),
        .o_lcd_data   (lcd_data2),
        .o_opnd_a     (opnd_a2),
        .o_opnd_b     (opnd_b2),
        .o_result     (result2),
        .o_result_vld (result_vld2),
        .o_state      (state2)
    );

    localparam logic [11:0] KENT = 12'h002;
    localparam logic [11:0] KCLR = 12'h001;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  echo_q[$];
    logic [11:0] res_exp_q[$];
    logic        vld_prev = 1'b0;

    function automatic logic [11:0] kd(input int d);
        logic [11:0] one;
        one = 12'd1;
        return one << (11 - d);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_echo(input logic [7:0] c);
`ifdef CALC_ECHO_EN
        echo_q.push_back(c);
`else
        if (c == 8'h00) echo_q.delete();
`endif
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input int sel, input logic [11:0] k, input int hold, input int gap);
        if (sel == 0) sw = k; else sw2 = k;
        tick(hold);
        if (sel == 0) sw = '0; else sw2 = '0;
        tick(gap);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"}, state, 0);
        check({tag, "_a"}, opnd_a, 0);
        check({tag, "_b"}, opnd_b, 0);
        check({tag, "_res"}, result, 0);
        check({tag, "_vld"}, result_vld, 0);
        check({tag, "_wr"}, lcd_wr, 0);
        check({tag, "_data"}, lcd_data, 8'h20);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            vld_prev = 1'b0;
        end else begin
            if (lcd_wr) begin
                if (echo_q.size() == 0) check("lcd_wr_unexpected", lcd_wr, 0);
                else check("lcd_data", lcd_data, echo_q.pop_front());
            end
            if (result_vld && !vld_prev) begin
                if (res_exp_q.size() == 0) begin
                    check("vld_unexpected", result_vld, 0);
                end else begin
                    check("result", result, res_exp_q.pop_front());
                    check("state_done", state, 3);
                end
            end
            vld_prev = result_vld;
        end
    end

    initial begin
        rst = 1'b1; sw = '0; sw2 = '0; busy = 1'b0; busy2 = 1'b0;
        tick(3);
        check_reset_vals("reset");
        rst = 1'b0;
        tick(2);

        // 12 + 34
        exp_echo("1"); press(0, kd(1), 6, 3);
        exp_echo("2"); press(0, kd(2), 6, 3);
        check("a_12", opnd_a, 8'h12);
        exp_echo("+"); press(0, KENT, 6, 3);
        check("state_b", state, 1);
        exp_echo("3"); press(0, kd(3), 6, 3);
        exp_echo("4"); press(0, kd(4), 6, 3);
        check("b_34", opnd_b, 8'h34);
        exp_echo("="); res_exp_q.push_back(12'h046);
        sw = KENT;
        tick(4);
        check("add_entry_state", state, 2);
        check("add_entry_vld", result_vld, 0);
`ifdef CALC_ECHO_EN
        check("echo_next_cycle", lcd_wr, 1);
`endif
        tick(1);
        check("add_mid_state", state, 2);
        check("add_mid_vld", result_vld, 0);
        tick(1);
        check("add_done_vld", result_vld, 1);
        check("add_done_res", result, 12'h046);
        sw = '0;
        tick(3);

        // 99 + 99, restarting from S_DONE
        exp_echo("9"); press(0, kd(9), 6, 3);
        check("restart_state", state, 0);
        check("restart_b", opnd_b, 0);
        check("restart_vld", result_vld, 0);
        exp_echo("9"); press(0, kd(9), 6, 3);
        exp_echo("+"); press(0, KENT, 6, 3);
        exp_echo("9"); press(0, kd(9), 6, 3);
        exp_echo("9"); press(0, kd(9), 6, 3);
        exp_echo("="); res_exp_q.push_back(12'h198);
        press(0, KENT, 6, 3);
        check("carry_res", result, 12'h198);
        check("carry_vld", result_vld, 1);

        // Third digit over the limit is ignored
        exp_echo("1"); press(0, kd(1), 6, 3);
        exp_echo("2"); press(0, kd(2), 6, 3);
        press(0, kd(3), 6, 3);
        check("a_max_digits", opnd_a, 8'h12);
        exp_echo("+"); press(0, KENT, 6, 3);
        exp_echo("5"); press(0, kd(5), 6, 3);
        check("b_05", opnd_b, 8'h05);
        exp_echo("="); res_exp_q.push_back(12'h017);
        press(0, KENT, 6, 3);
        check("res_017", result, 12'h017);

        // CLR, then bounce and multi-key patterns
        press(0, KCLR, 6, 3);
        check("clr_state", state, 0);
        check("clr_a", opnd_a, 0);
        check("clr_res", result, 0);
        check("clr_vld", result_vld, 0);
        sw = kd(7); tick(3);
        sw = 12'h0C0; tick(10);
        sw = '0; tick(4);
        check("bounce_a", opnd_a, 0);
        check("bounce_state", state, 0);

        // Busy LCD: 5 buffered, 6 dropped when echo is present
        busy = 1'b1;
        exp_echo("5"); press(0, kd(5), 6, 3);
        press(0, kd(6), 6, 3);
        check("wr_busy", lcd_wr, 0);
        busy = 1'b0;
        tick(4);
`ifdef CALC_ECHO_EN
        check("busy_a", opnd_a, 8'h05);
`else
        check("busy_a", opnd_a, 8'h56);
`endif

        // CLR aborting an add in progress (4-digit instance)
        press(1, kd(1), 3, 2);
        press(1, KENT, 3, 2);
        press(1, kd(2), 3, 2);
        check("d2_state_b", state2, 1);
        check("d2_a", opnd_a2, 16'h0001);
        check("d2_b", opnd_b2, 16'h0002);
        sw2 = KENT; tick(2);
        check("d2_add_state", state2, 2);
        sw2 = '0; tick(1);
        sw2 = KCLR; tick(1);
        check("d2_still_add", state2, 2);
        tick(1);
        check("d2_clr_state", state2, 0);
        check("d2_clr_a", opnd_a2, 0);
        check("d2_clr_b", opnd_b2, 0);
        check("d2_clr_res", result2, 0);
        check("d2_clr_vld", result_vld2, 0);
        sw2 = '0; tick(6);
        check("d2_vld_stays0", result_vld2, 0);
        check("d2_state_stays", state2, 0);

        // rst mid-entry
        press(0, KCLR, 6, 3);
        exp_echo("8"); press(0, kd(8), 6, 3);
        check("pre_rst_a", opnd_a, 8'h08);
        sw = kd(3); tick(2);
        rst = 1'b1; tick(1);
        check_reset_vals("rst_mid");
        rst = 1'b0; sw = '0; tick(1);
        check_reset_vals("post_rst");
        tick(4);

        check("echo_q_drained", echo_q.size(), 0);
        check("res_q_drained", res_exp_q.size(), 0);
`ifndef CALC_ECHO_EN
        check("lcd_data_const", lcd_data, 8'h20);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
